// File: rtl/sensor_switch_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sensor_switch_pkg
// Brief   : Shared FSM encoding and control/status bit indices for the
//           detector-interface path switch.
// Revision: 1.0 - initial release
// ============================================================================
package sensor_switch_pkg;

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_GUARD  = 2'd2
    } state_t;

    localparam int CTRL_SCLK_EN = 0;
    localparam int CTRL_RST     = 1;
    localparam int CTRL_INT     = 2;
    localparam int CTRL_SER     = 3;

    localparam int STAT_DV      = 0;
    localparam int STAT_LINE1   = 1;
    localparam int STAT_ERR     = 2;

    // Guard counter width covers GUARD_CYC up to 65535.
    localparam int GUARD_CNT_W  = 16;

endpackage
`default_nettype wire

// File: rtl/sensor_path_switch_sync2_bus.sv
`default_nettype none
// ============================================================================
// Module  : sync2_bus
// Brief   : Parametrised-width two-flop synchroniser with asynchronous
//           active-low clear and a synchronous flush of both stages.
// Revision: 1.0 - initial release
// ============================================================================
module sync2_bus #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else if (flush) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/sensor_path_switch.sv
`default_nettype none
// ============================================================================
// Module  : sensor_path_switch
// Brief   : Registered N-way router between the readout core and detector
//           targets; switches only at frame boundaries, followed by a guard
//           interval with all control lines low.
//           Optional drain timeout: define SENSOR_SWITCH_TIMEOUT_EN.
// Revision: 1.0 - initial release
// ============================================================================
module sensor_path_switch
    import sensor_switch_pkg::*;
#(
    parameter int N_CH        = 2,
    parameter int SEL_W       = 3,
    parameter int CTRL_W      = 4,
    parameter int STAT_W      = 3,
    parameter int GUARD_CYC   = 16,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [SEL_W-1:0]         sel_req,
    input  logic                     sel_stb,
    input  logic                     frame_idle,
    input  logic [CTRL_W-1:0]        ctrl_in,
    output logic [N_CH*CTRL_W-1:0]   ctrl_out,
    input  logic [N_CH*STAT_W-1:0]   stat_in,
    output logic [STAT_W-1:0]        stat_out,
    output logic [SEL_W-1:0]         active_sel,
    output logic                     busy,
    output logic                     sel_err,
    output logic                     timeout
);

    localparam int                     c_CTRL_BUS_W = N_CH * CTRL_W;
    localparam int                     c_STAT_BUS_W = N_CH * STAT_W;
    localparam logic [SEL_W:0]         c_N_CH       = (SEL_W+1)'(N_CH);
    localparam logic [GUARD_CNT_W-1:0] c_GUARD_LAST = GUARD_CNT_W'(GUARD_CYC - 1);

    state_t                  r_state;
    logic [SEL_W-1:0]        r_active_sel;
    logic [SEL_W-1:0]        r_target;
    logic [SEL_W-1:0]        r_pend_sel;
    logic                    r_pend_vld;
    logic                    r_busy;
    logic                    r_sel_err;
    logic [GUARD_CNT_W-1:0]  r_guard_cnt;
    logic [c_CTRL_BUS_W-1:0] r_ctrl_out;
    logic [STAT_W-1:0]       r_stat_out;

    logic [c_CTRL_BUS_W-1:0] w_ctrl_route;
    logic [STAT_W-1:0]       w_stat_mux;
    logic [c_STAT_BUS_W-1:0] w_stat_sync;
    logic                    w_req_valid;
    logic                    w_req_err;
    logic                    w_act_req_vld;
    logic [SEL_W-1:0]        w_act_req_sel;
    logic                    w_start;
    logic                    w_guard_done;
    logic                    w_to_expire;

    assign w_req_valid   = sel_stb && ({1'b0, sel_req} < c_N_CH);
    assign w_req_err     = sel_stb && !({1'b0, sel_req} < c_N_CH);

    // In ACTIVE a fresh strobe overrides any request left pending from the last switch.
    assign w_act_req_vld = w_req_valid || r_pend_vld;
    assign w_act_req_sel = w_req_valid ? sel_req : r_pend_sel;
    assign w_start       = (r_state == ST_ACTIVE) && w_act_req_vld
                           && (w_act_req_sel != r_active_sel);
    assign w_guard_done  = (r_state == ST_GUARD) && (r_guard_cnt == c_GUARD_LAST);

    sync2_bus #(
        .WIDTH (c_STAT_BUS_W)
    ) u_stat_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (w_guard_done),
        .d     (stat_in),
        .q     (w_stat_sync)
    );

    always_comb begin
        w_ctrl_route = '0;
        w_stat_mux   = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (r_active_sel == SEL_W'(k)) begin
                w_ctrl_route[k*CTRL_W +: CTRL_W] = ctrl_in;
                w_stat_mux                       = w_stat_sync[k*STAT_W +: STAT_W];
            end
        end
    end

`ifdef SENSOR_SWITCH_TIMEOUT_EN
    localparam int              c_TO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT_CYC - 1);

    logic [c_TO_W-1:0] r_to_cnt;
    logic              r_timeout;

    assign w_to_expire = (r_state == ST_DRAIN) && !frame_idle && (r_to_cnt == c_TO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt  <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_to_expire;
            if (r_state != ST_DRAIN) begin
                r_to_cnt <= '0;
            end else if (!frame_idle) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
        end
    end

    assign timeout = r_timeout;
`else
    assign w_to_expire = 1'b0;
    assign timeout     = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_ACTIVE;
            r_active_sel <= '0;
            r_target     <= '0;
            r_pend_sel   <= '0;
            r_pend_vld   <= 1'b0;
            r_busy       <= 1'b0;
            r_sel_err    <= 1'b0;
            r_guard_cnt  <= '0;
            r_ctrl_out   <= '0;
            r_stat_out   <= '0;
        end else begin
            r_sel_err  <= w_req_err;
            r_ctrl_out <= (r_state == ST_GUARD) ? '0 : w_ctrl_route;

            case (r_state)
                ST_ACTIVE: begin
                    r_stat_out <= w_stat_mux;
                    if (w_act_req_vld) begin
                        r_pend_vld <= 1'b0;
                    end
                    if (w_start) begin
                        r_state  <= ST_DRAIN;
                        r_target <= w_act_req_sel;
                        r_busy   <= 1'b1;
                    end
                end

                ST_DRAIN: begin
                    r_stat_out <= w_stat_mux;
                    if (w_req_valid) begin
                        r_pend_vld <= 1'b1;
                        r_pend_sel <= sel_req;
                    end
                    if (frame_idle || w_to_expire) begin
                        r_state     <= ST_GUARD;
                        r_guard_cnt <= '0;
                    end
                end

                ST_GUARD: begin
                    // A strobe on the terminal count is still captured as pending.
                    if (w_req_valid) begin
                        r_pend_vld <= 1'b1;
                        r_pend_sel <= sel_req;
                    end
                    if (w_guard_done) begin
                        r_state      <= ST_ACTIVE;
                        r_active_sel <= r_target;
                        r_busy       <= 1'b0;
                        r_stat_out   <= '0;
                    end else begin
                        r_guard_cnt  <= r_guard_cnt + 1'b1;
                    end
                end

                default: begin
                    r_state <= ST_ACTIVE;
                end
            endcase
        end
    end

    assign ctrl_out   = r_ctrl_out;
    assign stat_out   = r_stat_out;
    assign active_sel = r_active_sel;
    assign busy       = r_busy;
    assign sel_err    = r_sel_err;

endmodule
`default_nettype wire

// File: tb/tb_sensor_path_switch.sv
`default_nettype none
// ============================================================================
// Module  : tb_sensor_path_switch
// Brief   : Self-checking bench for sensor_path_switch with random control and
//           status traffic checked against a cycle-history reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_sensor_path_switch;

    localparam int N_CH        = 2;
    localparam int SEL_W       = 3;
    localparam int CTRL_W      = 4;
    localparam int STAT_W      = 3;
    localparam int GUARD_CYC   = 16;
    localparam int TIMEOUT_CYC = 64;

    logic                   clk        = 1'b0;
    logic                   rst_n      = 1'b0;
    logic [SEL_W-1:0]       sel_req    = '0;
    logic                   sel_stb    = 1'b0;
    logic                   frame_idle = 1'b0;
    logic [CTRL_W-1:0]      ctrl_in    = '0;
    logic [N_CH*CTRL_W-1:0] ctrl_out;
    logic [N_CH*STAT_W-1:0] stat_in    = '0;
    logic [STAT_W-1:0]      stat_out;
    logic [SEL_W-1:0]       active_sel;
    logic                   busy;
    logic                   sel_err;
    logic                   timeout;

    int n_cmp     = 0;
    int n_err     = 0;
    int cyc       = 0;
    int m_stat_ok = 3;

    logic [CTRL_W-1:0]      ctrl_hist [0:4095];
    logic [N_CH*STAT_W-1:0] stat_hist [0:4095];

    always #5 clk = ~clk;

    sensor_path_switch #(
        .N_CH        (N_CH),
        .SEL_W       (SEL_W),
        .CTRL_W      (CTRL_W),
        .STAT_W      (STAT_W),
        .GUARD_CYC   (GUARD_CYC),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sel_req    (sel_req),
        .sel_stb    (sel_stb),
        .frame_idle (frame_idle),
        .ctrl_in    (ctrl_in),
        .ctrl_out   (ctrl_out),
        .stat_in    (stat_in),
        .stat_out   (stat_out),
        .active_sel (active_sel),
        .busy       (busy),
        .sel_err    (sel_err),
        .timeout    (timeout)
    );

    // Expected control bus: the captured word placed in target sel's slice.
    function automatic logic [N_CH*CTRL_W-1:0] route(input logic [CTRL_W-1:0] v, input int sel);
        return (N_CH*CTRL_W)'(v) << (CTRL_W * sel);
    endfunction

    // Status appears three edges after it is applied, zero while the synchroniser refills.
    function automatic logic [STAT_W-1:0] exp_stat(input int sel);
        logic [N_CH*STAT_W-1:0] s;
        if (cyc < m_stat_ok) return '0;
        s = stat_hist[cyc-2];
        return STAT_W'(s >> (STAT_W * sel));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step_v(input logic [CTRL_W-1:0] c);
        ctrl_in = c;
        stat_in = (N_CH*STAT_W)'($urandom);
        ctrl_hist[cyc+1] = ctrl_in;
        stat_hist[cyc+1] = stat_in;
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic step();
        step_v(CTRL_W'($urandom));
    endtask

    task automatic chk_state(input string tag, input int sel, input int bsy);
        chk({tag, "_ctrl"}, 32'(ctrl_out), 32'(route(ctrl_hist[cyc], sel)));
        chk({tag, "_sel"},  32'(active_sel), sel);
        chk({tag, "_busy"}, 32'(busy), bsy);
        chk({tag, "_stat"}, 32'(stat_out), 32'(exp_stat(sel)));
        chk({tag, "_err"},  32'(sel_err), 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctrl"}, 32'(ctrl_out), 0);
        chk({tag, "_stat"}, 32'(stat_out), 0);
        chk({tag, "_sel"},  32'(active_sel), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_err"},  32'(sel_err), 0);
        chk({tag, "_to"},   32'(timeout), 0);
    endtask

    // One full switch: request, drain of drain_len cycles, guard, completion.
    // Up to two strobes may be placed at guard cycle offsets p1_at/p2_at (0 = none).
    task automatic do_switch(input int from, input int to, input int drain_len,
                             input bit skip_req, input bit forced,
                             input int p1_req, input int p1_at,
                             input int p2_req, input int p2_at,
                             output bit again);
        logic [STAT_W-1:0] held;
        int  last_req;
        bit  has_pend;
        has_pend = 1'b0;
        last_req = 0;
        if (!skip_req) begin
            sel_req    = SEL_W'(to);
            sel_stb    = 1'b1;
            frame_idle = (drain_len == 1) && !forced;
            step();
            sel_stb = 1'b0;
            chk_state("req", from, 1);
        end
        for (int d = 1; d <= drain_len; d++) begin
            frame_idle = !forced && (d >= drain_len);
            step();
            chk_state("drain", from, 1);
            chk("drain_to", 32'(timeout), (forced && d == drain_len) ? 1 : 0);
        end
        held = exp_stat(from);
        for (int j = 1; j <= GUARD_CYC; j++) begin
            if (j == 3) frame_idle = 1'b0;
            if (j == p1_at) begin sel_req = SEL_W'(p1_req); sel_stb = 1'b1; last_req = p1_req; has_pend = 1'b1; end
            if (j == p2_at) begin sel_req = SEL_W'(p2_req); sel_stb = 1'b1; last_req = p2_req; has_pend = 1'b1; end
            step();
            sel_stb = 1'b0;
            chk("guard_ctrl", 32'(ctrl_out), 0);
            chk("guard_to",   32'(timeout), 0);
            chk("guard_err",  32'(sel_err), 0);
            if (j < GUARD_CYC) begin
                chk("guard_sel",  32'(active_sel), from);
                chk("guard_busy", 32'(busy), 1);
                chk("guard_stat", 32'(stat_out), 32'(held));
            end else begin
                chk("done_sel",  32'(active_sel), to);
                chk("done_busy", 32'(busy), 0);
                chk("done_stat", 32'(stat_out), 0);
                m_stat_ok = cyc + 3;
            end
        end
        again = has_pend && (last_req != to);
        step();
        chk_state("post", to, again ? 1 : 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit again;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst_n     = 1'b1;
        cyc       = 0;
        m_stat_ok = 3;

        step_v(4'b1010);
        chk("first_ctrl", 32'(ctrl_out), 32'h0A);
        chk_state("first", 0, 0);
        repeat (8) begin step(); chk_state("track0", 0, 0); end

        // Main switch 0->1 with frame boundary 20 cycles after the request.
        do_switch(0, 1, 20, 1'b0, 1'b0, 0, 0, 0, 0, again);
        repeat (6) begin step(); chk_state("track1", 1, 0); end

        // Out-of-range requests are rejected with a single-cycle error pulse.
        for (int i = 0; i < 3; i++) begin
            sel_req = (i == 0) ? SEL_W'(3) : SEL_W'($urandom_range(N_CH, 7));
            sel_stb = 1'b1;
            step();
            sel_stb = 1'b0;
            chk("err_pulse", 32'(sel_err), 1);
            chk("err_sel",   32'(active_sel), 1);
            chk("err_busy",  32'(busy), 0);
            chk("err_ctrl",  32'(ctrl_out), 32'(route(ctrl_hist[cyc], 1)));
            step();
            chk_state("err_after", 1, 0);
        end

        // Request for the already active target does nothing.
        sel_req = 1;
        sel_stb = 1'b1;
        step();
        sel_stb = 1'b0;
        chk_state("same", 1, 0);
        step();
        chk_state("same2", 1, 0);

        // Frame already idle at the request: one-cycle drain.
        do_switch(1, 0, 1, 1'b0, 1'b0, 0, 0, 0, 0, again);
        repeat (4) begin step(); chk_state("track0b", 0, 0); end

        // Guard strobes 0 then 1: last wins, equals new target, no second switch.
        do_switch(0, 1, 3, 1'b0, 1'b0, 0, 5, 1, 10, again);
        repeat (5) begin step(); chk_state("no_second", 1, 0); end

        // Final strobe on the terminal count differs: immediate switch back.
        do_switch(1, 0, 2, 1'b0, 1'b0, 0, 4, 1, GUARD_CYC, again);
        do_switch(0, 1, 2, 1'b1, 1'b0, 0, 0, 0, 0, again);
        repeat (5) begin step(); chk_state("track1b", 1, 0); end

        // Reset in the middle of the guard with a pending request.
        sel_req    = 0;
        sel_stb    = 1'b1;
        frame_idle = 1'b1;
        step();
        sel_stb = 1'b0;
        step();
        frame_idle = 1'b0;
        repeat (4) step();
        sel_req = 1;
        sel_stb = 1'b1;
        step();
        sel_stb = 1'b0;
        step();
        chk("mid_guard_busy", 32'(busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        repeat (2) begin step(); chk_all_zero("in_rst"); end
        rst_n     = 1'b1;
        m_stat_ok = cyc + 3;
        repeat (25) begin step(); chk_state("post_rst", 0, 0); end

`ifdef SENSOR_SWITCH_TIMEOUT_EN
        // Frame never idles: the drain is forced into the guard by the timeout.
        do_switch(0, 1, TIMEOUT_CYC, 1'b0, 1'b1, 0, 0, 0, 0, again);
        repeat (4) begin step(); chk_state("after_to", 1, 0); end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sensor_path_switch.md
Name: sensor_path_switch

Overview:
- Registered N-way router for the detector interface.
- Control lines go from the readout core to one of N_CH targets: bolometer, test pattern generators, loopback.
- Status lines return from the selected target. Non-selected targets are driven low.
- Channel changes happen only at a frame boundary, followed by a guard interval with all control outputs low, so no target ever sees a truncated frame or runt pulse.

Parameters:
- N_CH, 2, number of targets (2..8).
- SEL_W, 3, select width; must satisfy 2**SEL_W >= N_CH.
- CTRL_W, 4, control lines per target (bit order: sensor clock-enable, sensor reset, INT, SERDATA).
- STAT_W, 3, status lines per target (bit order: DATAVALID, LINE1, ERROR).
- GUARD_CYC, 16, guard-interval length in CLK cycles (1..65535).
- TIMEOUT_CYC, 4096, drain timeout in cycles; used only with the optional feature.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  asynchronous active-low reset.
- SEL_REQ  in  SEL_W  requested target index.
- SEL_STB  in  1  one-cycle strobe; qualifies SEL_REQ.
- FRAME_IDLE  in  1  high when the readout core is between frames (safe to switch).
- CTRL_IN  in  CTRL_W  control lines from the readout core.
- CTRL_OUT  out  N_CH*CTRL_W  per-target control lines; target k uses slice [k*CTRL_W +: CTRL_W].
- STAT_IN  in  N_CH*STAT_W  per-target status lines; asynchronous to CLK.
- STAT_OUT  out  STAT_W  status of the active target.
- ACTIVE_SEL  out  SEL_W  currently routed target.
- BUSY  out  1  high while a switch is in progress.
- SEL_ERR  out  1  one-cycle pulse when a request is rejected.
- TIMEOUT  out  1  one-cycle pulse on a forced switch (optional feature only; otherwise tied 0).

Behaviour:
Reset (RESET=0, asynchronous):
- CTRL_OUT=0, STAT_OUT=0, ACTIVE_SEL=0, BUSY=0, SEL_ERR=0, TIMEOUT=0.
- FSM enters ACTIVE, pending request cleared, synchronisers cleared.

Datapath:
- ACTIVE state: CTRL_OUT slice[ACTIVE_SEL] = CTRL_IN, registered, 1-cycle latency. All other slices are 0.
- STAT_IN passes through a 2-flop synchroniser per bit, then a registered mux on ACTIVE_SEL, giving 3-cycle latency to STAT_OUT.

Request handling:
- SEL_STB with SEL_REQ >= N_CH: SEL_ERR pulses the next cycle; request ignored; no state change.
- Valid SEL_STB while in ACTIVE with SEL_REQ == ACTIVE_SEL: no action, no error.
- Valid SEL_STB while BUSY: stored as the pending request (last strobe wins). It is applied when the current switch completes, as a new switch unless it equals the new ACTIVE_SEL.

FSM:
- ACTIVE: a valid differing request, or a pending request at switch completion, goes to DRAIN. BUSY rises the next cycle.
- DRAIN: routing unchanged. Go to GUARD on the first cycle FRAME_IDLE=1.
  - If FRAME_IDLE is already 1 when the request arrives, DRAIN lasts exactly 1 cycle.
- GUARD: all CTRL_OUT = 0; STAT_OUT held at its last value. The guard counter counts GUARD_CYC cycles.
  - On the final count: ACTIVE_SEL <= target, synchronisers flushed to 0, next state ACTIVE.
- Back in ACTIVE: BUSY drops in the same cycle ACTIVE_SEL updates. The new target's CTRL_OUT follows CTRL_IN from the next cycle.
- STAT_OUT remains 0 for 3 cycles after the switch until the synchroniser refills.

Boundary conditions:
- SEL_STB in the same cycle as the GUARD terminal count is treated as pending.
- FRAME_IDLE falling during GUARD is ignored; the guard is never aborted.
- Reset mid-switch returns to target 0 immediately.

Optional Feature:
- Macro: SENSOR_SWITCH_TIMEOUT_EN.
- Defined: DRAIN carries a counter. If FRAME_IDLE stays 0 for TIMEOUT_CYC cycles, the FSM forces entry to GUARD and pulses TIMEOUT for 1 cycle at entry.
- Undefined: DRAIN waits indefinitely; TIMEOUT is tied 0; no counter logic is synthesised.

Decomposition:
- Shared package sensor_switch_pkg holds:
  - FSM state encoding (ST_ACTIVE, ST_DRAIN, ST_GUARD).
  - Control/status bit index constants: CTRL_SCLK_EN=0, CTRL_RST=1, CTRL_INT=2, CTRL_SER=3, STAT_DV=0, STAT_LINE1=1, STAT_ERR=2.
- One sub-module: sync2_bus, a parametrised-width 2-flop synchroniser with asynchronous active-low clear and synchronous flush. It is instantiated once over the full N_CH*STAT_W bus.

Test Plan:
- Reset, then CTRL_IN=4'b1010 → CTRL_OUT[3:0]=1010 one cycle later; CTRL_OUT[7:4]=0; ACTIVE_SEL=0; BUSY=0.
- With FRAME_IDLE=0, SEL_REQ=1 plus SEL_STB; FRAME_IDLE raised 20 cycles later:
  - CTRL_OUT[3:0] keeps following CTRL_IN for those 20 cycles.
  - Then all CTRL_OUT = 0 for exactly 16 cycles.
  - Then ACTIVE_SEL=1 and BUSY falls.
  - STAT_OUT tracks STAT_IN[5:3] after 3 cycles.
- With N_CH=2, SEL_REQ=3 plus SEL_STB → SEL_ERR pulses for 1 cycle; ACTIVE_SEL, BUSY and CTRL_OUT are unchanged.
- During a 0→1 switch, strobe SEL_REQ=0 then SEL_REQ=1 in the guard interval:
  - Last wins (1 equals the new ACTIVE_SEL), so no second switch occurs.
  - Repeating with the final strobe SEL_REQ=0 → a second switch back to 0 follows immediately.
- RESET asserted mid-GUARD → all outputs 0 asynchronously; ACTIVE_SEL=0 after release; the pending request is discarded.
- With SENSOR_SWITCH_TIMEOUT_EN and TIMEOUT_CYC=64, FRAME_IDLE held at 0 → TIMEOUT pulses 64 cycles after DRAIN entry; the guard interval and switch then complete normally.
